// File: rtl/alu7_pkg.sv
// -----------------------------------------------------------------------------
// alu7_pkg
// Shared definitions for the 7-bit registered ALU (alu7_nand_rol).
//   ALU7_WIDTH : default operand/result width
//   alu7_op_e  : 2-bit opcode encoding (all four codes are used)
// -----------------------------------------------------------------------------
package alu7_pkg;

    localparam int ALU7_WIDTH = 7;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_ROL  = 2'b10,
        OP_NAND = 2'b11
    } alu7_op_e;

endpackage : alu7_pkg

// File: rtl/alu7_rotl.sv
// -----------------------------------------------------------------------------
// alu7_rotl
// Combinational rotate-left. The rotate amount is reduced modulo WIDTH first,
// so any amount value is legal.
// Ports:
//   a   : input  [WIDTH-1:0]  value to rotate
//   amt : input  [WIDTH-1:0]  rotate amount (taken modulo WIDTH)
//   y   : output [WIDTH-1:0]  rotated value
// -----------------------------------------------------------------------------
module alu7_rotl
    import alu7_pkg::*;
#(
    parameter int WIDTH = ALU7_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] amt,
    output logic [WIDTH-1:0] y
);

    localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [AW-1:0] n_s;
    logic [AW:0]   shamt_s;

    // Reduce the amount modulo WIDTH, then rotate by right-shifting a doubled
    // copy of the operand by (WIDTH - n). n = 0 shifts by WIDTH, giving y = a.
    always_comb begin
        n_s     = AW'(amt % WIDTH);
        shamt_s = (AW + 1)'(WIDTH) - {1'b0, n_s};
        y       = WIDTH'({a, a} >> shamt_s);
    end

endmodule : alu7_rotl

// File: rtl/alu7_nand_rol.sv
// -----------------------------------------------------------------------------
// alu7_nand_rol
// 7-bit registered ALU: ADD, SUB, ROL, NAND. Operands are sampled when
// in_valid is high and the result appears one clock later with out_valid.
// When in_valid is low, out_valid drops and r/flags hold.
// Optional status flags are enabled by defining the macro ALU7_FLAGS_EN;
// otherwise zero and carry are tied to 0 and no flag logic exists.
// Ports:
//   clk       : input            rising-edge clock
//   rst       : input            asynchronous active-high reset
//   in_valid  : input            sample a/b/op this cycle
//   a, b      : input  [WIDTH-1:0] operands (b is the rotate amount for ROL)
//   op        : input  [1:0]     00 ADD, 01 SUB, 10 ROL, 11 NAND
//   out_valid : output           r holds a new result this cycle
//   r         : output [WIDTH-1:0] registered result
//   zero      : output           result == 0 (ALU7_FLAGS_EN only)
//   carry     : output           ADD carry-out / SUB borrow (ALU7_FLAGS_EN only)
// -----------------------------------------------------------------------------
module alu7_nand_rol
    import alu7_pkg::*;
#(
    parameter int WIDTH = ALU7_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    output logic [WIDTH-1:0] r,
    output logic             zero,
    output logic             carry
);

    logic [WIDTH-1:0] rot_s;
    logic [WIDTH-1:0] res_s;
    logic [WIDTH-1:0] r_r;
    logic             out_valid_r;

    alu7_rotl #(
        .WIDTH (WIDTH)
    ) u_rotl (
        .a   (a),
        .amt (b),
        .y   (rot_s)
    );

    // Operation select for the next result.
    always_comb begin
        res_s = '0;
        case (alu7_op_e'(op))
            OP_ADD:  res_s = a + b;
            OP_SUB:  res_s = a - b;
            OP_ROL:  res_s = rot_s;
            OP_NAND: res_s = ~(a & b);
            default: res_s = '0;
        endcase
    end

    // Result and valid registers; r holds whenever nothing is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_r         <= '0;
            out_valid_r <= 1'b0;
        end else if (in_valid) begin
            r_r         <= res_s;
            out_valid_r <= 1'b1;
        end else begin
            r_r         <= r_r;
            out_valid_r <= 1'b0;
        end
    end

    assign r         = r_r;
    assign out_valid = out_valid_r;

`ifdef ALU7_FLAGS_EN
    logic [WIDTH:0] sum_ext_s;
    logic           carry_next_s;
    logic           zero_next_s;
    logic           carry_r;
    logic           zero_r;

    // Next-state flags: carry is the ADD carry-out or the SUB borrow.
    always_comb begin
        sum_ext_s    = {1'b0, a} + {1'b0, b};
        carry_next_s = 1'b0;
        case (alu7_op_e'(op))
            OP_ADD:  carry_next_s = sum_ext_s[WIDTH];
            OP_SUB:  carry_next_s = (a < b);
            OP_ROL:  carry_next_s = 1'b0;
            OP_NAND: carry_next_s = 1'b0;
            default: carry_next_s = 1'b0;
        endcase
        zero_next_s = (res_s == '0);
    end

    // Flag registers, loaded together with r.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_r <= 1'b0;
            zero_r  <= 1'b0;
        end else if (in_valid) begin
            carry_r <= carry_next_s;
            zero_r  <= zero_next_s;
        end else begin
            carry_r <= carry_r;
            zero_r  <= zero_r;
        end
    end

    assign carry = carry_r;
    assign zero  = zero_r;
`else
    assign carry = 1'b0;
    assign zero  = 1'b0;
`endif

endmodule : alu7_nand_rol

// File: tb/tb_alu7_nand_rol.sv
// -----------------------------------------------------------------------------
// tb_alu7_nand_rol
// Directed self-checking bench for alu7_nand_rol. Flag expectations apply
// when ALU7_FLAGS_EN is defined; otherwise zero and carry must stay 0.
// -----------------------------------------------------------------------------
module tb_alu7_nand_rol;

`ifdef ALU7_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [6:0] a;
    logic [6:0] b;
    logic [1:0] op;
    logic       out_valid;
    logic [6:0] r;
    logic       zero;
    logic       carry;

    int checks;
    int errors;

    alu7_nand_rol dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .r         (r),
        .zero      (zero),
        .carry     (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare all outputs against one expected result.
    task automatic chk_all(input string tag, input logic ev, input logic [6:0] er,
                           input logic ec, input logic ez);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
        chk({tag, ".r"},         32'(r),         32'(er));
        chk({tag, ".carry"},     32'(carry),     32'(ec & FLAGS));
        chk({tag, ".zero"},      32'(zero),      32'(ez & FLAGS));
    endtask

    // Present one operation for the next rising edge, then sample after it.
    task automatic issue(input logic [6:0] ta, input logic [6:0] tb, input logic [1:0] top);
        @(negedge clk);
        in_valid = 1'b1;
        a        = ta;
        b        = tb;
        op       = top;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = 7'd0;
        b        = 7'd0;
        op       = 2'b00;

        #2;
        chk_all("reset", 1'b0, 7'b0000000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // ADD
        issue(7'b1010101, 7'b0101010, 2'b00);
        chk_all("add", 1'b1, 7'b1111111, 1'b0, 1'b0);

        // SUB, no borrow then borrow
        issue(7'b1110000, 7'b0000011, 2'b01);
        chk_all("sub", 1'b1, 7'b1101101, 1'b0, 1'b0);
        issue(7'b0000000, 7'b0000001, 2'b01);
        chk_all("sub_borrow", 1'b1, 7'b1111111, 1'b1, 1'b0);

        // ROL: n=4, n=7 (mod 7 = 0), n=11 (mod 7 = 4)
        issue(7'b0001111, 7'b0000100, 2'b10);
        chk_all("rol4", 1'b1, 7'b1110001, 1'b0, 1'b0);
        issue(7'b0001111, 7'b0000111, 2'b10);
        chk_all("rol7", 1'b1, 7'b0001111, 1'b0, 1'b0);
        issue(7'b0001111, 7'b0001011, 2'b10);
        chk_all("rol11", 1'b1, 7'b1110001, 1'b0, 1'b0);

        // NAND
        issue(7'b1111111, 7'b0000001, 2'b11);
        chk_all("nand", 1'b1, 7'b1111110, 1'b0, 1'b0);
        issue(7'b1111111, 7'b1111111, 2'b11);
        chk_all("nand_zero", 1'b1, 7'b0000000, 1'b0, 1'b1);

        // Back-to-back: in_valid stays high across four edges
        issue(7'b0000001, 7'b0000001, 2'b00);
        chk_all("b2b0", 1'b1, 7'b0000010, 1'b0, 1'b0);
        issue(7'b0000101, 7'b0000101, 2'b01);
        chk_all("b2b1", 1'b1, 7'b0000000, 1'b0, 1'b1);
        issue(7'b1000000, 7'b0000001, 2'b10);
        chk_all("b2b2", 1'b1, 7'b0000001, 1'b0, 1'b0);
        issue(7'b1111111, 7'b0000001, 2'b00);
        chk_all("b2b3", 1'b1, 7'b0000000, 1'b1, 1'b1);

        // Idle: out_valid drops, r and flags hold even though inputs change
        @(negedge clk);
        in_valid = 1'b0;
        a        = 7'b0101010;
        b        = 7'b0010101;
        op       = 2'b11;
        @(posedge clk);
        #1;
        chk_all("idle", 1'b0, 7'b0000000, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        chk_all("idle2", 1'b0, 7'b0000000, 1'b1, 1'b1);

        // Asynchronous reset between edges while out_valid is high
        issue(7'b0000000, 7'b0000000, 2'b11);
        chk_all("pre_rst", 1'b1, 7'b1111111, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 1'b0, 7'b0000000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk_all("rst_held", 1'b0, 7'b0000000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // First accept after reset release
        issue(7'b0000011, 7'b0000100, 2'b00);
        chk_all("post_rst", 1'b1, 7'b0000111, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_alu7_nand_rol

// File: doc/alu7_nand_rol.md
Name: alu7_nand_rol

Overview:
- 7-bit registered ALU with four operations: ADD, SUB, rotate-left (ROL) and NAND.
- Used as a small datapath execution unit.
- Operands and opcode are sampled on a valid strobe; the result appears one clock later with its own valid flag.
- Optional zero/carry status flags.

Parameters:
- WIDTH, 7, operand/result width in bits. Rotate amount is taken modulo WIDTH.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  when high, a/b/op are sampled this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B (rotate amount for ROL).
- op  input  2  opcode: 00 ADD, 01 SUB, 10 ROL, 11 NAND.
- out_valid  output  1  r (and flags) hold a new result this cycle.
- r  output  WIDTH  registered result.
- zero  output  1  result == 0 (FLAGS_EN only; else tied 0).
- carry  output  1  ADD carry-out / SUB borrow (FLAGS_EN only; else tied 0).

Behaviour:
- Reset (async, rst=1): r=0, out_valid=0, zero=0, carry=0 immediately. This holds while rst is high.
- Latency is 1 cycle. On a rising clk edge with in_valid=1:
  - r <= f(a,b,op).
  - out_valid <= 1.
- On a rising clk edge with in_valid=0:
  - out_valid <= 0.
  - r and the flags hold their previous values.
- No backpressure. A new op may be accepted every cycle (full throughput).
- ADD: r = (a+b) mod 2^WIDTH; carry = bit WIDTH of a+b.
- SUB: r = (a-b) mod 2^WIDTH (two's complement); carry = 1 iff a<b (borrow).
- ROL: n = b mod WIDTH (unsigned); r = (a<<n | a>>(WIDTH-n)) truncated to WIDTH; n=0 gives r=a; carry=0.
- NAND: r = ~(a & b) bitwise; carry=0.
- zero = (r_next == 0), registered together with r.
- Purely combinational function otherwise. There is no undefined opcode, since all 4 codes are used.
- Reset asserted mid-stream: the pending result is discarded and out_valid drops asynchronously. The first accept after rst deasserts behaves normally.

Optional Feature:
- Macro ALU7_FLAGS_EN.
- Defined: zero and carry are computed and registered as above.
- Undefined: both are constant 0, and no flag logic is synthesized. r/out_valid behaviour is identical.

Decomposition:
- Package alu7_pkg:
  - WIDTH default constant.
  - Opcode enum alu7_op_e (OP_ADD=2'b00, OP_SUB=2'b01, OP_ROL=2'b10, OP_NAND=2'b11).
- One natural sub-module, alu7_rotl: combinational parameterized rotate-left including the mod-WIDTH amount reduction.
- Top contains the op mux, flag logic and output registers.

Test Plan:
- ADD: a=1010101, b=0101010, op=00, in_valid=1 -> next cycle r=1111111, out_valid=1, carry=0, zero=0.
- SUB: a=1110000, b=0000011, op=01 -> r=1101101, carry=0. Then a=0000000, b=0000001 -> r=1111111, carry=1.
- ROL: a=0001111, b=0000100, op=10 -> r=1110001. b=0000111 (n=0) -> r=0001111. b=0001011 (n=4) -> r=1110001.
- NAND: a=1111111, b=0000001, op=11 -> r=1111110. a=b=1111111 -> r=0000000, zero=1.
- Hold/throughput:
  - Back-to-back in_valid on 4 cycles gives 4 consecutive results with out_valid=1.
  - in_valid=0 -> out_valid=0 and r unchanged.
- Reset: assert rst asynchronously between clock edges while out_valid=1 -> r=0, out_valid=0 immediately. After release, the next accept works normally.
